// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared constants for the fetch, decode and jump-control stages.
//   ADDR_W / INSTR_W    : program memory address and instruction widths
//   RESET_PC / NOP_WORD : reset fetch address and bubble instruction
//   OP_*                : opcode constants shared with decode and jump control
//   fetch_act_e         : per-cycle action chosen by the fetch unit
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int          ADDR_W   = 16;
    localparam int          INSTR_W  = 32;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Opcode constants used by decode and jump control.
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_JZ  = 6'b011100;
    localparam logic [5:0] OP_JNZ = 6'b011101;
    localparam logic [5:0] OP_JV  = 6'b011110;
    localparam logic [5:0] OP_JNV = 6'b011111;

    // Action taken by the fetch unit on the next rising edge.
    // Encoded in priority order: reset > redirect > stall > advance.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_RESET    = 2'd3
    } fetch_act_e;

    // True for any opcode that may redirect the fetch stream.
    function automatic logic is_flow_opcode(input logic [5:0] op);
        logic r;
        case (op)
            OP_JMP, OP_RET, OP_JZ, OP_JNZ, OP_JV, OP_JNV: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_hold.sv
// -----------------------------------------------------------------------------
// pc_hold_buffer
// One-entry stall buffer plus the instruction output mux.
// While decode stalls, program memory keeps being read at the next fetch
// address, so the word currently on pm_data would be lost; it is captured on
// the first stall edge and replayed until the stall releases.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   capture_i    : current cycle is a stall (no redirect)
//   valid_i      : fetch slot holds a real instruction
//   pm_data_i    : program memory read data
//   hold_v_o     : buffer holds a captured word
//   ins_o        : instruction presented to decode
// -----------------------------------------------------------------------------
module pc_hold_buffer
    import pc_fetch_pkg::*;
#(
    parameter int                 IW       = pc_fetch_pkg::INSTR_W,
    parameter logic [IW-1:0]      NOP_INS  = pc_fetch_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture_i,
    input  logic          valid_i,
    input  logic [IW-1:0] pm_data_i,
    output logic          hold_v_o,
    output logic [IW-1:0] ins_o
);

    logic [IW-1:0] hold_q, hold_d;
    logic          hold_v_q, hold_v_d;

    // Next-state: capture once on stall entry, keep while stalled, drop otherwise.
    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (capture_i) begin
            if (!hold_v_q) begin
                hold_d   = pm_data_i;
                hold_v_d = 1'b1;
            end else begin
                hold_d   = hold_q;
                hold_v_d = 1'b1;
            end
        end else begin
            hold_v_d = 1'b0;
        end
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q   <= {IW{1'b0}};
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    // Output mux: held word first, then live memory data, else a bubble.
    always_comb begin
        if (hold_v_q) begin
            ins_o = hold_q;
        end else if (valid_i) begin
            ins_o = pm_data_i;
        end else begin
            ins_o = NOP_INS;
        end
    end

    assign hold_v_o = hold_v_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and instruction-fetch stage feeding decode.
// Program memory is synchronous: data for pm_addr appears on pm_data one
// cycle later, so addr_q tracks which address the word on pm_data belongs to.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   jmp_loc          : redirect target from jump control
//   pc_mux_sel       : redirect request (wins over stall)
//   stall            : decode back-pressure
//   pm_data          : program memory read data
//   pm_addr          : program memory read address (= pc)
//   ins, ins_valid   : instruction to decode and its valid flag
//   current_address  : address of ins
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = pc_fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = pc_fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = pc_fetch_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_WORD = pc_fetch_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  jmp_loc,
    input  logic               pc_mux_sel,
    input  logic               stall,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [INSTR_W-1:0] ins,
    output logic               ins_valid,
    output logic [ADDR_W-1:0]  current_address
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    fetch_act_e        act_s;
    logic              hold_v_s;

    // Pick this cycle's action in priority order.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (reset) begin
            act_s = ACT_RESET;
        end else if (pc_mux_sel) begin
            act_s = ACT_REDIRECT;
        end else if (stall) begin
            act_s = ACT_STALL;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Next-state for pc, slot address and slot valid.
    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        case (act_s)
            ACT_ADVANCE: begin
                addr_d  = pc_q;
                pc_d    = pc_q + PC_ONE;   // wraps modulo 2^ADDR_W
                valid_d = 1'b1;
            end
            ACT_REDIRECT: begin
                // The slot for the old pc is the wrong path: squash it.
                addr_d  = pc_q;
                pc_d    = jmp_loc;
                valid_d = 1'b0;
            end
            ACT_STALL: begin
                pc_d    = pc_q;
                addr_d  = addr_q;
                valid_d = valid_q;
            end
            ACT_RESET: begin
                pc_d    = RESET_PC;
                addr_d  = RESET_PC;
                valid_d = 1'b0;
            end
            default: begin
                pc_d    = RESET_PC;
                addr_d  = RESET_PC;
                valid_d = 1'b0;
            end
        endcase
    end

    // PC, slot address and valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    pc_hold_buffer #(
        .IW      (INSTR_W),
        .NOP_INS (NOP_WORD)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .capture_i (act_s == ACT_STALL),
        .valid_i   (valid_q),
        .pm_data_i (pm_data),
        .hold_v_o  (hold_v_s),
        .ins_o     (ins)
    );

    assign pm_addr         = pc_q;
    assign current_address = addr_q;
    assign ins_valid       = valid_q;

    // The hold flag is only needed inside the buffer's mux.
    logic unused_s;
    assign unused_s = hold_v_s;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic        stall;
    logic [31:0] pm_data;
    logic [15:0] pm_addr;
    logic [31:0] ins;
    logic        ins_valid;
    logic [15:0] current_address;

    int total;
    int bad;

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .stall           (stall),
        .pm_data         (pm_data),
        .pm_addr         (pm_addr),
        .ins             (ins),
        .ins_valid       (ins_valid),
        .current_address (current_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents: M[a] = 0xA000_0000 + a.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    // Synchronous program memory, one cycle read latency.
    always @(posedge clk) pm_data <= mem_word(pm_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a valid slot: address a on ins/current_address, pm_addr one ahead.
    task automatic chk_slot(input string tag, input logic [15:0] a);
        logic [15:0] nxt;
        nxt = a + 16'h0001;
        chk({tag, ".ins"}, ins, mem_word(a));
        chk({tag, ".addr"}, {16'h0000, current_address}, {16'h0000, a});
        chk({tag, ".valid"}, {31'h0, ins_valid}, 32'h1);
        chk({tag, ".pm_addr"}, {16'h0000, pm_addr}, {16'h0000, nxt});
    endtask

    task automatic chk_bubble(input string tag, input logic [15:0] pa);
        chk({tag, ".ins"}, ins, 32'h0000_0000);
        chk({tag, ".valid"}, {31'h0, ins_valid}, 32'h0);
        chk({tag, ".pm_addr"}, {16'h0000, pm_addr}, {16'h0000, pa});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        jmp_loc    = 16'h0000;
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        pm_data    = 32'h0000_0000;

        // Reset state
        step();
        step();
        chk_bubble("reset", 16'h0000);
        chk("reset.addr", {16'h0000, current_address}, 32'h0);

        // 1. free run
        reset = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            step();
            chk_slot("run", i[15:0]);
        end

        // 2. stall three cycles with ins = M[5]
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_slot("stall", 16'h0005);
        end
        stall = 1'b0;
        step();
        chk_slot("release", 16'h0006);
        for (int i = 7; i <= 16; i++) begin
            step();
        end
        chk_slot("pre_jmp", 16'h0010);

        // 3. redirect to 0x0040
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0040;
        step();
        chk_bubble("jmp_bubble", 16'h0040);
        pc_mux_sel = 1'b0;
        step();
        chk_slot("jmp_target", 16'h0040);

        // 4. stall to fill the hold buffer, then redirect while still stalled
        stall = 1'b1;
        step();
        chk_slot("stall_pre_redir", 16'h0040);
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'hF000;
        step();
        chk_bubble("redir_stall_bubble", 16'hF000);
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        step();
        chk_slot("redir_stall_target", 16'hF000);

        // Back-to-back redirects: last target wins, bubble each cycle
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0100;
        step();
        chk_bubble("b2b_first", 16'h0100);
        jmp_loc = 16'h0200;
        step();
        chk_bubble("b2b_second", 16'h0200);
        pc_mux_sel = 1'b0;
        step();
        chk_slot("b2b_target", 16'h0200);

        // 5. wrap through 0xFFFF
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'hFFFD;
        step();
        chk_bubble("wrap_bubble", 16'hFFFD);
        pc_mux_sel = 1'b0;
        step();
        chk_slot("wrap_fffd", 16'hFFFD);
        step();
        chk_slot("wrap_fffe", 16'hFFFE);
        step();
        chk_slot("wrap_ffff", 16'hFFFF);
        step();
        chk_slot("wrap_0000", 16'h0000);
        step();
        chk_slot("wrap_0001", 16'h0001);

        // 6. reset while stalled with a held word
        stall = 1'b1;
        step();
        chk_slot("stall_pre_reset", 16'h0001);
        reset = 1'b1;
        step();
        chk_bubble("reset_mid_stall", 16'h0000);
        chk("reset_mid_stall.addr", {16'h0000, current_address}, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        chk_slot("after_reset", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
